// File: rtl/sy_pkg.sv
// sy_pkg: D$ geometry defaults, flush FSM state encoding and line-address helper.
package sy_pkg;
  localparam int SETS   = 64;
  localparam int WAYS   = 4;
  localparam int LINE_W = 512;
  localparam int TAG_W  = 20;
  localparam int OFFS_W = 6;
  localparam int AWTH   = 64;
  typedef enum logic [3:0] {
    IDLE, WAIT_IDLE, RD_TAG, CHK, RD_DATA, WB, INV, NEXT, ACK, REL
  } flush_state_e;
  function automatic logic [63:0] line_addr(input logic [63:0] tag, input logic [63:0] set,
                                            input int set_w, input int offs_w);
    return (tag << (set_w + offs_w)) | (set << offs_w);
  endfunction
endpackage

// File: rtl/sy_dcache_flush_unit_if.sv
// sy_dcache_flush_unit_if: flush handshake, D$ tag/data array and writeback port bundle.
// master = flush unit, slave = pipeline controller / D$ arrays / memory side.
interface sy_dcache_flush_unit_if #(
  parameter int SETS   = sy_pkg::SETS,
  parameter int WAYS   = sy_pkg::WAYS,
  parameter int LINE_W = sy_pkg::LINE_W,
  parameter int TAG_W  = sy_pkg::TAG_W,
  parameter int AWTH   = sy_pkg::AWTH
);
  localparam int SW = $clog2(SETS);
  localparam int WW = WAYS > 1 ? $clog2(WAYS) : 1;
  logic              flush_req_i;
  logic              flush_ack_o;
  logic              flush_busy_o;
  logic              cache_idle_i;
  logic              tag_rd_en_o;
  logic [SW-1:0]     tag_set_o;
  logic [WW-1:0]     tag_way_o;
  logic              tag_rd_valid_i;
  logic              tag_rd_dirty_i;
  logic [TAG_W-1:0]  tag_rd_tag_i;
  logic              tag_wr_en_o;
  logic              data_rd_en_o;
  logic [LINE_W-1:0] data_rd_i;
  logic              wb_req_o;
  logic [AWTH-1:0]   wb_addr_o;
  logic [LINE_W-1:0] wb_data_o;
  logic              wb_gnt_i;
  logic [31:0]       flush_wb_cnt_o;
  modport master (
    input  flush_req_i, cache_idle_i, tag_rd_valid_i, tag_rd_dirty_i, tag_rd_tag_i, data_rd_i, wb_gnt_i,
    output flush_ack_o, flush_busy_o, tag_rd_en_o, tag_set_o, tag_way_o, tag_wr_en_o, data_rd_en_o,
           wb_req_o, wb_addr_o, wb_data_o, flush_wb_cnt_o
  );
  modport slave (
    output flush_req_i, cache_idle_i, tag_rd_valid_i, tag_rd_dirty_i, tag_rd_tag_i, data_rd_i, wb_gnt_i,
    input  flush_ack_o, flush_busy_o, tag_rd_en_o, tag_set_o, tag_way_o, tag_wr_en_o, data_rd_en_o,
           wb_req_o, wb_addr_o, wb_data_o, flush_wb_cnt_o
  );
endinterface

// File: rtl/sy_flush_walker.sv
// sy_flush_walker: set/way walk counter, way-major, flags the final (SETS-1, WAYS-1) line.
module sy_flush_walker #(
  parameter int SETS = 4,
  parameter int WAYS = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                inc_i,
  output logic [$clog2(SETS)-1:0]             set_o,
  output logic [(WAYS > 1 ? $clog2(WAYS) : 1)-1:0] way_o,
  output logic                                last_o
);
  localparam int SW = $clog2(SETS);
  localparam int WW = WAYS > 1 ? $clog2(WAYS) : 1;
  logic way_wrap;
  assign way_wrap = way_o == WW'(WAYS - 1);
  assign last_o   = way_wrap && set_o == SW'(SETS - 1);
  // both fields wrap to zero on the last line, leaving the counters cleared for the next flush
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      set_o <= '0;
      way_o <= '0;
    end else if (inc_i) begin
      way_o <= way_wrap ? '0 : way_o + 1'b1;
      set_o <= way_wrap ? set_o + 1'b1 : set_o;
    end
  end
endmodule

// File: rtl/sy_dcache_flush_unit.sv
// sy_dcache_flush_unit: walks every D$ set/way, writes back dirty lines and invalidates all.
// Define SY_DCACHE_FLUSH_PERF_EN to get a saturating count of written-back lines on flush_wb_cnt_o.
module sy_dcache_flush_unit
  import sy_pkg::*;
#(
  parameter int SETS   = sy_pkg::SETS,
  parameter int WAYS   = sy_pkg::WAYS,
  parameter int LINE_W = sy_pkg::LINE_W,
  parameter int TAG_W  = sy_pkg::TAG_W,
  parameter int OFFS_W = sy_pkg::OFFS_W,
  parameter int AWTH   = sy_pkg::AWTH
) (
  input logic                    clk_i,
  input logic                    rst_i,
  sy_dcache_flush_unit_if.master bus
);
  localparam int SW = $clog2(SETS);
  localparam int WW = WAYS > 1 ? $clog2(WAYS) : 1;
  flush_state_e      state_q, state_d;
  logic [TAG_W-1:0]  tag_q;
  logic [LINE_W-1:0] line_q;
  logic [SW-1:0]     set_q;
  logic [WW-1:0]     way_q;
  logic              last, hit;
  sy_flush_walker #(.SETS(SETS), .WAYS(WAYS)) u_walker (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (state_q == NEXT),
    .set_o (set_q),
    .way_o (way_q),
    .last_o(last)
  );
  assign hit = bus.tag_rd_valid_i & bus.tag_rd_dirty_i;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      tag_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == CHK && hit) tag_q <= bus.tag_rd_tag_i;
      if (state_q == RD_DATA) line_q <= bus.data_rd_i;
    end
  end
  // REL holds until the request drops so a lingering request never starts a second walk
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = bus.flush_req_i ? WAIT_IDLE : IDLE;
      WAIT_IDLE: state_d = bus.cache_idle_i ? RD_TAG : WAIT_IDLE;
      RD_TAG:    state_d = CHK;
      CHK:       state_d = hit ? RD_DATA : INV;
      RD_DATA:   state_d = WB;
      WB:        state_d = bus.wb_gnt_i ? INV : WB;
      INV:       state_d = NEXT;
      NEXT:      state_d = last ? ACK : RD_TAG;
      ACK:       state_d = REL;
      REL:       state_d = bus.flush_req_i ? REL : IDLE;
      default:   state_d = IDLE;
    endcase
  end
  assign bus.flush_busy_o = state_q != IDLE && state_q != REL;
  assign bus.flush_ack_o  = state_q == ACK;
  assign bus.tag_rd_en_o  = state_q == RD_TAG;
  assign bus.tag_wr_en_o  = state_q == INV;
  assign bus.data_rd_en_o = state_q == CHK && hit;
  assign bus.wb_req_o     = state_q == WB;
  assign bus.tag_set_o    = set_q;
  assign bus.tag_way_o    = way_q;
  assign bus.wb_addr_o    = AWTH'(line_addr(64'(tag_q), 64'(set_q), SW, OFFS_W));
  assign bus.wb_data_o    = line_q;
`ifdef SY_DCACHE_FLUSH_PERF_EN
  logic [31:0] wb_cnt_q;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) wb_cnt_q <= '0;
    else if (state_q == WB && bus.wb_gnt_i && !(&wb_cnt_q)) wb_cnt_q <= wb_cnt_q + 1'b1;
  end
  assign bus.flush_wb_cnt_o = wb_cnt_q;
`else
  assign bus.flush_wb_cnt_o = '0;
`endif
endmodule

// File: tb/tb_sy_dcache_flush_unit.sv
// tb_sy_dcache_flush_unit: D$ array/memory model around the flush unit; writebacks checked via scoreboard.
module tb_sy_dcache_flush_unit;
  localparam int S = 4, W = 2, LW = 512, TW = 20, OW = 6, AW = 64, N = S * W, SB = 2;
  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
  } wb_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  sy_dcache_flush_unit_if #(.SETS(S), .WAYS(W), .LINE_W(LW), .TAG_W(TW), .AWTH(AW)) bus ();
  sy_dcache_flush_unit #(.SETS(S), .WAYS(W), .LINE_W(LW), .TAG_W(TW), .OFFS_W(OW), .AWTH(AW)) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus  (bus)
  );
  wb_t sb[$];
  int checks = 0, errors = 0;
  logic valid[N], dirty[N];
  logic [TW-1:0] tags[N];
  logic [LW-1:0] lines[N];
  int n_ack, n_trd, n_twr, n_hs, n_req, gnt_dly, wcnt, exp_wb;
  logic in_wb;
  logic [AW-1:0] cap_a;
  logic [LW-1:0] cap_d;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // tag/data arrays: one-cycle read latency, tag writes invalidate
  initial begin
    bus.tag_rd_valid_i = 1'b0;
    bus.tag_rd_dirty_i = 1'b0;
    bus.tag_rd_tag_i   = '0;
    bus.data_rd_i      = '0;
    forever @(posedge clk) begin
      int ix;
      ix = int'(bus.tag_set_o) * W + int'(bus.tag_way_o);
      if (bus.tag_rd_en_o) begin
        bus.tag_rd_valid_i <= valid[ix];
        bus.tag_rd_dirty_i <= dirty[ix];
        bus.tag_rd_tag_i   <= tags[ix];
      end
      if (bus.data_rd_en_o) bus.data_rd_i <= lines[ix];
      if (bus.tag_wr_en_o) begin
        valid[ix] <= 1'b0;
        dirty[ix] <= 1'b0;
      end
    end
  end

  // memory side: grant after gnt_dly waiting cycles, scoreboard pop on each handshake
  initial begin
    bus.wb_gnt_i = 1'b0;
    in_wb = 1'b0;
    wcnt = 0;
    forever @(negedge clk) begin
      wb_t e;
      n_ack += int'(bus.flush_ack_o);
      n_trd += int'(bus.tag_rd_en_o);
      n_twr += int'(bus.tag_wr_en_o);
      if (bus.wb_req_o) begin
        if (!in_wb) begin
          cap_a = bus.wb_addr_o;
          cap_d = bus.wb_data_o;
          in_wb = 1'b1;
        end else begin
          check("wb_addr_stable", LW'(bus.wb_addr_o), LW'(cap_a));
          check("wb_data_stable", bus.wb_data_o, cap_d);
        end
        n_req++;
        bus.wb_gnt_i = wcnt >= gnt_dly;
        wcnt++;
        if (bus.wb_gnt_i) begin
          n_hs++;
          wcnt = 0;
          in_wb = 1'b0;
          if (sb.size() == 0) check("sb_underflow", LW'(1), LW'(0));
          else begin
            e = sb.pop_front();
            check("wb_addr", LW'(bus.wb_addr_o), LW'(e.addr));
            check("wb_data", bus.wb_data_o, e.data);
          end
        end
      end else begin
        bus.wb_gnt_i = 1'b0;
        in_wb = 1'b0;
        wcnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic reset_counts();
    n_ack = 0; n_trd = 0; n_twr = 0; n_hs = 0; n_req = 0;
  endtask

  task automatic add_dirty(input int i, input logic [TW-1:0] t, input logic [LW-1:0] d);
    wb_t e;
    valid[i] = 1'b1;
    dirty[i] = 1'b1;
    tags[i]  = t;
    lines[i] = d;
    e.addr = (AW'(t) << (OW + SB)) | (AW'(i / W) << OW);
    e.data = d;
    sb.push_back(e);
    exp_wb++;
  endtask

  // lat counts the request cycle as 1 and the ack cycle inclusively
  task automatic flush(input int max, output int lat);
    bus.flush_req_i = 1'b1;
    lat = 1;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.flush_ack_o && lat < max);
    check("ack_seen", LW'(bus.flush_ack_o), LW'(1));
  endtask

  task automatic end_flush();
    bus.flush_req_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_cnt(input string tag);
`ifdef SY_DCACHE_FLUSH_PERF_EN
    check(tag, LW'(bus.flush_wb_cnt_o), LW'(exp_wb));
`else
    check(tag, LW'(bus.flush_wb_cnt_o), LW'(0));
`endif
  endtask

  task automatic check_all_invalid(input string tag);
    int live;
    live = 0;
    for (int i = 0; i < N; i++) live += int'(valid[i] | dirty[i]);
    check(tag, LW'(live), LW'(0));
  endtask

  initial begin
    int lat;
    logic b;
    bus.flush_req_i = 1'b0;
    bus.cache_idle_i = 1'b1;
    gnt_dly = 0;
    exp_wb = 0;
    for (int i = 0; i < N; i++) begin
      valid[i] = 1'b0; dirty[i] = 1'b0; tags[i] = '0; lines[i] = '0;
    end
    reset_counts();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack", LW'(bus.flush_ack_o), LW'(0));
    check("rst_busy", LW'(bus.flush_busy_o), LW'(0));
    check("rst_tag_rd", LW'(bus.tag_rd_en_o), LW'(0));
    check("rst_tag_wr", LW'(bus.tag_wr_en_o), LW'(0));
    check("rst_wb_req", LW'(bus.wb_req_o), LW'(0));
    check("rst_wb_addr", LW'(bus.wb_addr_o), LW'(0));
    check("rst_set_way", LW'({bus.tag_set_o, bus.tag_way_o}), LW'(0));
    check_cnt("rst_cnt");
    rst_n = 1'b1;
    @(negedge clk);

    // all lines invalid
    reset_counts();
    flush(200, lat);
    check("t1_latency", LW'(lat), LW'(4 * N + 3));
    end_flush();
    check("t1_tag_wr", LW'(n_twr), LW'(N));
    check("t1_tag_rd", LW'(n_trd), LW'(N));
    check("t1_wb_req", LW'(n_req), LW'(0));
    check("t1_acks", LW'(n_ack), LW'(1));

    // single dirty line at set 2 way 1, grant delayed 5 cycles
    reset_counts();
    gnt_dly = 5;
    add_dirty(5, 20'h12345, {16{32'hCAFE0005}});
    flush(300, lat);
    check("t2_latency", LW'(lat), LW'(4 * N + 3 + 7));
    end_flush();
    check("t2_handshakes", LW'(n_hs), LW'(1));
    check("t2_req_cycles", LW'(n_req), LW'(6));
    check("t2_tag_wr", LW'(n_twr), LW'(N));
    check_all_invalid("t2_invalidated");
    check_cnt("t2_cnt");

    // cache busy for 10 cycles after the request
    reset_counts();
    gnt_dly = 0;
    bus.cache_idle_i = 1'b0;
    bus.flush_req_i = 1'b1;
    b = 1'b1;
    repeat (10) begin
      @(negedge clk);
      b &= bus.flush_busy_o;
    end
    check("t3_busy_while_wait", LW'(b), LW'(1));
    check("t3_no_tag_rd", LW'(n_trd), LW'(0));
    bus.cache_idle_i = 1'b1;
    flush(200, lat);
    check("t3_latency", LW'(lat), LW'(4 * N + 2));
    end_flush();
    check("t3_tag_rd", LW'(n_trd), LW'(N));

    // request held 3 cycles past ack
    reset_counts();
    flush(200, lat);
    b = 1'b0;
    repeat (3) begin
      @(negedge clk);
      b |= bus.flush_busy_o;
    end
    check("t4_busy_in_rel", LW'(b), LW'(0));
    end_flush();
    repeat (3) @(negedge clk);
    check("t4_acks", LW'(n_ack), LW'(1));
    check("t4_tag_rd", LW'(n_trd), LW'(N));
    check("t4_idle_busy", LW'(bus.flush_busy_o), LW'(0));

    // async reset while a writeback waits for grant
    reset_counts();
    gnt_dly = 1000;
    add_dirty(1, 20'hABCDE, {16{32'h5A5A0001}});
    bus.flush_req_i = 1'b1;
    for (int i = 0; i < 100 && !bus.wb_req_o; i++) @(negedge clk);
    check("t5_wb_req_seen", LW'(bus.wb_req_o), LW'(1));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_wb_req", LW'(bus.wb_req_o), LW'(0));
    check("t5_rst_busy", LW'(bus.flush_busy_o), LW'(0));
    check("t5_rst_ack", LW'(bus.flush_ack_o), LW'(0));
    check("t5_rst_wb_addr", LW'(bus.wb_addr_o), LW'(0));
    check("t5_rst_wb_data", bus.wb_data_o, LW'(0));
    check("t5_rst_strobes", LW'({bus.tag_rd_en_o, bus.tag_wr_en_o, bus.data_rd_en_o}), LW'(0));
    check("t5_rst_cnt", LW'(bus.flush_wb_cnt_o), LW'(0));
    bus.flush_req_i = 1'b0;
    sb.delete();
    exp_wb = 0;
    add_dirty(1, 20'hABCDE, {16{32'h5A5A0001}});
    @(negedge clk);
    rst_n = 1'b1;
    gnt_dly = 0;
    @(negedge clk);
    reset_counts();
    flush(200, lat);
    check("t5_latency", LW'(lat), LW'(4 * N + 3 + 2));
    end_flush();
    check("t5_handshakes", LW'(n_hs), LW'(1));
    check("t5_tag_wr", LW'(n_twr), LW'(N));
    check_cnt("t5_cnt");

    // every line dirty, grant always ready
    reset_counts();
    for (int i = 0; i < N; i++)
      add_dirty(i, TW'(20'h80000 + i * 3), {$urandom(), {15{32'h0}}} | LW'(i + 1));
    flush(400, lat);
    check("t6_latency", LW'(lat), LW'(4 * N + 3 + 2 * N));
    end_flush();
    check("t6_handshakes", LW'(n_hs), LW'(N));
    check_all_invalid("t6_invalidated");
    check_cnt("t6_cnt");
    check("sb_empty", LW'(sb.size()), LW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
